// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-group PC generator with prioritised redirects and a pending-redirect latch
module pc_gen #(
    parameter int                 ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC    = 32'hbfc0_0000,
    parameter int                 FETCH_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_adel,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              redir_pend
);

    localparam logic [ADDR_W-1:0] GRP_MASK = ADDR_W'(FETCH_BYTES - 1);
    localparam logic [ADDR_W-1:0] GRP_STEP = ADDR_W'(FETCH_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              vld_q;
    logic              pend_q, pend_d;
    logic              pend_exc_q, pend_exc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic              fire;
    logic              redir_hit;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] seq_pc;

    assign fetch_pc    = pc_q;
    assign fetch_valid = vld_q & ~stall;
    assign fetch_adel  = |pc_q[1:0];
    assign redir_pend  = pend_q;
    assign fire        = fetch_valid & fetch_ready;
    assign seq_pc      = (pc_q & ~GRP_MASK) + GRP_STEP;

    // Incoming beats pending within a class; exc beats br across classes.
    always_comb begin
        redir_hit = 1'b1;
        redir_pc  = pend_pc_q;
        if (exc_valid) begin
            redir_pc = exc_pc;
        end else if (pend_q && pend_exc_q) begin
            redir_pc = pend_pc_q;
        end else if (br_valid) begin
            redir_pc = br_pc;
        end else if (pend_q) begin
            redir_pc = pend_pc_q;
        end else begin
            redir_hit = 1'b0;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_exc_d = pend_exc_q;
        pend_pc_d  = pend_pc_q;
        if (!stall) begin
            if (redir_hit) begin
                pc_d   = redir_pc;
                pend_d = 1'b0;
            end else if (fire) begin
                pc_d = pred_valid ? pred_pc : seq_pc;
            end
        end else if (exc_valid) begin
            pend_d     = 1'b1;
            pend_exc_d = 1'b1;
            pend_pc_d  = exc_pc;
        end else if (br_valid && !(pend_q && pend_exc_q)) begin
            pend_d     = 1'b1;
            pend_exc_d = 1'b0;
            pend_pc_d  = br_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            vld_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            vld_q      <= 1'b1;
            pend_q     <= pend_d;
            pend_exc_q <= pend_exc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_adel;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        redir_pend;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen #(.ADDR_W(32), .RESET_PC(RST_PC), .FETCH_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_adel(fetch_adel),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .br_valid(br_valid), .br_pc(br_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .redir_pend(redir_pend)
    );

    always #5 clk = ~clk;

    // Reference model: current request address, liveness, and a one-deep list of held redirects
    logic [31:0] m_pc;
    bit          m_vld;
    bit          m_pend;
    bit          m_pexc;
    logic [31:0] m_ppc;

    task automatic model_reset();
        m_pc = RST_PC; m_vld = 0; m_pend = 0; m_pexc = 0; m_ppc = 0;
    endtask

    // Advance one clock: compute the model's next state from the inputs, then clock the DUT.
    task automatic step();
        bit          go;
        logic [31:0] tgt;
        go = 1; tgt = 0;
        if (exc_valid)             tgt = exc_pc;
        else if (m_pend && m_pexc) tgt = m_ppc;
        else if (br_valid)         tgt = br_pc;
        else if (m_pend)           tgt = m_ppc;
        else                       go = 0;
        if (!stall) begin
            if (go) begin
                m_pc = tgt; m_pend = 0;
            end else if (m_vld && fetch_ready) begin
                m_pc = pred_valid ? pred_pc : (m_pc / 8) * 8 + 8;
            end
        end else if (exc_valid) begin
            m_pend = 1; m_pexc = 1; m_ppc = exc_pc;
        end else if (br_valid && !(m_pend && m_pexc)) begin
            m_pend = 1; m_pexc = 0; m_ppc = br_pc;
        end
        m_vld = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; fetch_ready = 0; exc_valid = 0; br_valid = 0; pred_valid = 0;
        exc_pc = 0; br_pc = 0; pred_pc = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (fetch_pc !== RST_PC || fetch_valid !== 1'b0 || fetch_adel !== 1'b0 || redir_pend !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: pc=%h v=%b adel=%b pend=%b want pc=%h v=0 adel=0 pend=0",
                         fetch_pc, fetch_valid, fetch_adel, redir_pend, RST_PC);
            end
        end
        rst_n = 1;
        step();
        n_cmp++;
        if (fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL boot_valid: got %b want 1", fetch_valid);
        end
        fetch_ready = 1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (fetch_pc !== RST_PC + 32'(8 * i)) begin
                n_err++; $display("FAIL boot_seq%0d: got %h want %h", i, fetch_pc, RST_PC + 32'(8 * i));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        fetch_ready = 1; br_valid = 1; br_pc = 32'h8000_0004;
        step();
        br_valid = 0; fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (fetch_pc !== 32'h8000_0004 || fetch_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold%0d: got pc=%h v=%b want pc=80000004 v=1", i, fetch_pc, fetch_valid);
            end
            step();
        end
        fetch_ready = 1;
        step();
        n_cmp++;
        if (fetch_pc !== 32'h8000_0008) begin
            n_err++; $display("FAIL bp_align: got %h want 80000008", fetch_pc);
        end
        step();
        n_cmp++;
        if (fetch_pc !== 32'h8000_0010) begin
            n_err++; $display("FAIL bp_next: got %h want 80000010", fetch_pc);
        end
    endtask

    task automatic test_stall_redirect();
        fetch_ready = 1; stall = 1; br_valid = 1; br_pc = 32'h1000;
        #1;
        n_cmp++;
        if (fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_valid: got %b want 0", fetch_valid);
        end
        step();
        br_valid = 0; exc_valid = 1; exc_pc = 32'h2000;
        n_cmp++;
        if (redir_pend !== 1'b1 || fetch_pc !== m_pc) begin
            n_err++; $display("FAIL stall_pend: got pend=%b pc=%h want pend=1 pc=%h", redir_pend, fetch_pc, m_pc);
        end
        step();
        exc_valid = 0;
        step();
        stall = 0;
        step();
        n_cmp++;
        if (fetch_pc !== 32'h2000 || redir_pend !== 1'b0) begin
            n_err++; $display("FAIL stall_release: got pc=%h pend=%b want pc=00002000 pend=0", fetch_pc, redir_pend);
        end
    endtask

    task automatic test_priority();
        fetch_ready = 1; pred_valid = 1; pred_pc = 32'h4000; br_valid = 1; br_pc = 32'h5000;
        step();
        n_cmp++;
        if (fetch_pc !== 32'h5000) begin
            n_err++; $display("FAIL prio_br_over_pred: got %h want 00005000", fetch_pc);
        end
        br_valid = 0;
        step();
        n_cmp++;
        if (fetch_pc !== 32'h4000) begin
            n_err++; $display("FAIL prio_pred: got %h want 00004000", fetch_pc);
        end
        pred_valid = 0;
    endtask

    task automatic test_wrap_misalign();
        fetch_ready = 1; exc_valid = 1; exc_pc = 32'hffff_fff8;
        step();
        exc_valid = 0;
        step();
        n_cmp++;
        if (fetch_pc !== 32'h0000_0000) begin
            n_err++; $display("FAIL wrap: got %h want 00000000", fetch_pc);
        end
        exc_valid = 1; exc_pc = 32'h3002;
        step();
        exc_valid = 0;
        n_cmp++;
        if (fetch_pc !== 32'h3002 || fetch_adel !== 1'b1) begin
            n_err++; $display("FAIL adel_set: got pc=%h adel=%b want pc=00003002 adel=1", fetch_pc, fetch_adel);
        end
        step();
        n_cmp++;
        if (fetch_pc !== 32'h3008 || fetch_adel !== 1'b0) begin
            n_err++; $display("FAIL adel_next: got pc=%h adel=%b want pc=00003008 adel=0", fetch_pc, fetch_adel);
        end
    endtask

    task automatic test_async_reset();
        stall = 1; br_valid = 1; br_pc = 32'h7000;
        step();
        br_valid = 0;
        n_cmp++;
        if (redir_pend !== 1'b1) begin
            n_err++; $display("FAIL ares_pre_pend: got %b want 1", redir_pend);
        end
        stall = 0;
        #1 rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (fetch_pc !== RST_PC || fetch_valid !== 1'b0 || redir_pend !== 1'b0 || fetch_adel !== 1'b0) begin
            n_err++; $display("FAIL ares_immediate: pc=%h v=%b pend=%b adel=%b want pc=%h v=0 pend=0 adel=0",
                              fetch_pc, fetch_valid, redir_pend, fetch_adel, RST_PC);
        end
        @(negedge clk);
        rst_n = 1; fetch_ready = 0;
        step();
        n_cmp++;
        if (redir_pend !== 1'b0 || fetch_pc !== RST_PC || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL ares_after: pend=%b pc=%h v=%b want pend=0 pc=%h v=1",
                              redir_pend, fetch_pc, fetch_valid, RST_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            exc_valid   = ($urandom_range(0, 9) == 0);
            br_valid    = ($urandom_range(0, 5) == 0);
            pred_valid  = ($urandom_range(0, 3) == 0);
            exc_pc      = $urandom;
            br_pc       = $urandom & 32'hffff_fffc;
            pred_pc     = $urandom;
            #1;
            n_cmp++;
            if (fetch_pc !== m_pc || fetch_valid !== (m_vld && !stall) ||
                fetch_adel !== (m_pc % 4 != 0) || redir_pend !== m_pend) begin
                n_err++;
                $display("FAIL rand%0d: pc=%h v=%b adel=%b pend=%b want pc=%h v=%b adel=%b pend=%b", i,
                         fetch_pc, fetch_valid, fetch_adel, redir_pend,
                         m_pc, m_vld && !stall, m_pc % 4 != 0, m_pend);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_stall_redirect();
        test_priority();
        test_wrap_misalign();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
